// File: rtl/demux_1to2_stream.sv
// demux_1to2_stream
// Registered 1-to-2 stream demultiplexer. One input valid/ready stream is
// steered either by i_sel or by a ping-pong pointer into one of two
// single-entry output registers. Each channel keeps a wrapping count of the
// words it has accepted. The o_ready output is combinational from the
// destination consumer's ready, so a full channel can drain and refill in
// the same cycle without a bubble.

module demux_1to2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_sel,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_data1,
  output logic             o_valid1,
  input  logic             i_ready1,
  output logic [WIDTH-1:0] o_data2,
  output logic             o_valid2,
  input  logic             i_ready2,
  output logic [7:0]       o_cnt1,
  output logic [7:0]       o_cnt2
);

  localparam int NCH = 2;

  // Per-channel views. Index 0 is channel 1 and index 1 is channel 2, which
  // matches the encoding of i_sel and of the ping-pong pointer.
  logic [NCH-1:0]   ch_ready;
  logic [NCH-1:0]   ch_valid;
  logic [NCH-1:0]   ch_space;
  logic [NCH-1:0]   ch_load;
  logic [WIDTH-1:0] ch_data [NCH];
  logic [7:0]       ch_cnt  [NCH];

  // Ping-pong pointer: the channel that takes the next word in mode 1.
  logic             ptr_q;
  logic             ptr_d;

  logic             dest;
  logic             accept;

  assign ch_ready = {i_ready2, i_ready1};

  // Destination select, space check and accept decode. o_ready looks only at
  // the destination channel, so ping-pong order stays strict even when the
  // other channel is free. i_valid is deliberately kept out of o_ready.
  always_comb begin
    dest     = i_mode ? ptr_q : i_sel;
    ch_space = ~ch_valid | ch_ready;
    o_ready  = !i_rst && ch_space[dest];
    accept   = i_valid && o_ready;
    ch_load  = '0;
    if (accept) begin
      ch_load[dest] = 1'b1;
    end
  end

  // Pointer next state: held at channel 1 while steering by i_sel so that
  // entering ping-pong always starts at channel 1; advances only on accept.
  always_comb begin
    ptr_d = ptr_q;
    if (!i_mode) begin
      ptr_d = 1'b0;
    end else if (accept) begin
      ptr_d = ~ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // One output register plus word counter per channel.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;

    // Refill wins over drain, so a word consumed and replaced in the same
    // cycle keeps valid high. Data is only overwritten by a new word; after
    // a drain the last word stays visible with valid low.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (ch_load[gi]) begin
        valid_d = 1'b1;
        data_d  = i_data;
        cnt_d   = cnt_q + 8'd1;
      end else if (valid_q && ch_ready[gi]) begin
        valid_d = 1'b0;
      end
    end

    // Channel state registers; reset discards any held word outright.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        cnt_q   <= 8'd0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        cnt_q   <= cnt_d;
      end
    end

    assign ch_valid[gi] = valid_q;
    assign ch_data[gi]  = data_q;
    assign ch_cnt[gi]   = cnt_q;
  end

  assign o_valid1 = ch_valid[0];
  assign o_valid2 = ch_valid[1];
  assign o_data1  = ch_data[0];
  assign o_data2  = ch_data[1];
  assign o_cnt1   = ch_cnt[0];
  assign o_cnt2   = ch_cnt[1];

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Directed bench for demux_1to2_stream. A queue-level model (held word
// count, last word, accept counts, next ping-pong channel, delivery logs)
// is compared against the DUT every cycle; literal checks pin the scenarios.

module tb_demux_1to2_stream;

  logic       clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic       i_sel = 1'b0;
  logic       i_mode = 1'b0;
  logic [7:0] o_data1;
  logic       o_valid1;
  logic       i_ready1 = 1'b0;
  logic [7:0] o_data2;
  logic       o_valid2;
  logic       i_ready2 = 1'b0;
  logic [7:0] o_cnt1;
  logic [7:0] o_cnt2;

  int tests = 0;
  int fails = 0;

  // Words handed to each consumer, in order.
  logic [7:0] got1[$];
  logic [7:0] got2[$];

  always #5 clk = ~clk;

  demux_1to2_stream #(.WIDTH(8)) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_sel    (i_sel),
    .i_mode   (i_mode),
    .o_data1  (o_data1),
    .o_valid1 (o_valid1),
    .i_ready1 (i_ready1),
    .o_data2  (o_data2),
    .o_valid2 (o_valid2),
    .i_ready2 (i_ready2),
    .o_cnt1   (o_cnt1),
    .o_cnt2   (o_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model and per-cycle compare. Inputs change 1ns after the falling edge;
  // o_ready is checked 4ns after it, registered outputs 1ns after the rise.
  initial begin : compare
    int         held [2];
    logic [7:0] last [2];
    int         cnt  [2];
    int         nxt;
    logic       rd   [2];
    int         dst;
    logic       room;
    logic       take;
    held = '{0, 0};
    last = '{8'h00, 8'h00};
    cnt  = '{0, 0};
    nxt  = 0;
    forever begin
      @(negedge clk);
      #4;
      rd[0] = i_ready1;
      rd[1] = i_ready2;
      if (i_rst) begin
        held = '{0, 0};
        last = '{8'h00, 8'h00};
        cnt  = '{0, 0};
        nxt  = 0;
        chk("cmp_ready_in_reset", {31'd0, o_ready}, 32'd0);
      end else begin
        dst  = i_mode ? nxt : int'(i_sel);
        room = (held[dst] == 0) || rd[dst];
        chk("cmp_ready", {31'd0, o_ready}, {31'd0, room});
        take = i_valid && room;
        for (int c = 0; c < 2; c++) begin
          if (held[c] != 0 && rd[c]) begin
            held[c] = 0;
            if (c == 0) got1.push_back(last[c]);
            else        got2.push_back(last[c]);
          end
        end
        if (take) begin
          held[dst] = 1;
          last[dst] = i_data;
          cnt[dst]  = (cnt[dst] + 1) % 256;
        end
        if (!i_mode)   nxt = 0;
        else if (take) nxt = 1 - nxt;
      end
      @(posedge clk);
      #1;
      chk("cmp_valid1", {31'd0, o_valid1}, (held[0] != 0) ? 32'd1 : 32'd0);
      chk("cmp_valid2", {31'd0, o_valid2}, (held[1] != 0) ? 32'd1 : 32'd0);
      chk("cmp_data1", {24'd0, o_data1}, {24'd0, last[0]});
      chk("cmp_data2", {24'd0, o_data2}, {24'd0, last[1]});
      chk("cmp_cnt1", {24'd0, o_cnt1}, 32'(cnt[0]));
      chk("cmp_cnt2", {24'd0, o_cnt2}, 32'(cnt[1]));
    end
  end

  // One clock of stimulus; returns o_ready as seen just before the edge and
  // leaves time 2ns after the edge so post-edge state can be inspected.
  task automatic tick(input logic v, input logic [7:0] d, input logic s, input logic m,
                      input logic r1, input logic r2, output logic rdy);
    @(negedge clk);
    #1;
    i_valid  = v;
    i_data   = d;
    i_sel    = s;
    i_mode   = m;
    i_ready1 = r1;
    i_ready2 = r2;
    #3;
    rdy = o_ready;
    @(posedge clk);
    #2;
    $display("[TB] t=%0t v=%0b d=%02h sel=%0b mode=%0b r1=%0b r2=%0b rdy=%0b | v1=%0b d1=%02h c1=%0d v2=%0b d2=%02h c2=%0d",
             $time, v, d, s, m, r1, r2, rdy, o_valid1, o_data1, o_cnt1, o_valid2, o_data2, o_cnt2);
  endtask

  // Hold reset across one clock edge, then release it.
  task automatic do_reset();
    @(negedge clk);
    #1;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    #2;
    @(negedge clk);
    #1;
    i_rst = 1'b0;
    @(posedge clk);
    #2;
  endtask

  logic rdy;

  initial begin : stim
    // Reset state
    #1 i_rst = 1'b1;
    #2;
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    @(posedge clk);
    #2;
    chk("rst_valid1", {31'd0, o_valid1}, 32'd0);
    chk("rst_valid2", {31'd0, o_valid2}, 32'd0);
    chk("rst_data1", {24'd0, o_data1}, 32'd0);
    chk("rst_cnt2", {24'd0, o_cnt2}, 32'd0);
    @(negedge clk);
    #1 i_rst = 1'b0;
    @(posedge clk);
    #2;

    // Steer to channel 1
    tick(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
    chk("steer_rdy1", {31'd0, rdy}, 32'd1);
    chk("steer_d11", {24'd0, o_data1}, 32'h11);
    chk("steer_v1", {31'd0, o_valid1}, 32'd1);
    tick(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
    chk("steer_d22", {24'd0, o_data1}, 32'h22);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
    chk("steer_cnt1", {24'd0, o_cnt1}, 32'd2);
    chk("steer_cnt2", {24'd0, o_cnt2}, 32'd0);
    chk("steer_v2", {31'd0, o_valid2}, 32'd0);

    // Backpressure hold on channel 2, then release with no bubble
    tick(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, rdy);
    chk("bp_dA5", {24'd0, o_data2}, 32'hA5);
    tick(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, rdy);
    chk("bp_stall_rdy", {31'd0, rdy}, 32'd0);
    chk("bp_hold_d", {24'd0, o_data2}, 32'hA5);
    chk("bp_hold_v", {31'd0, o_valid2}, 32'd1);
    tick(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, rdy);
    chk("bp_release_rdy", {31'd0, rdy}, 32'd1);
    chk("bp_d5A", {24'd0, o_data2}, 32'h5A);
    chk("bp_nobubble_v", {31'd0, o_valid2}, 32'd1);
    chk("bp_cnt2", {24'd0, o_cnt2}, 32'd2);
    tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, rdy);
    chk("bp_drained_v", {31'd0, o_valid2}, 32'd0);
    chk("bp_keep_d", {24'd0, o_data2}, 32'h5A);

    // Ping-pong
    do_reset();
    got1.delete();
    got2.delete();
    for (int k = 1; k <= 4; k++) begin
      tick(1'b1, 8'(k), 1'b0, 1'b1, 1'b1, 1'b1, rdy);
      chk("pp_rdy", {31'd0, rdy}, 32'd1);
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, rdy);
    chk("pp_n1", 32'(got1.size()), 32'd2);
    chk("pp_n2", 32'(got2.size()), 32'd2);
    if (got1.size() == 2 && got2.size() == 2) begin
      chk("pp_ch1_0", {24'd0, got1[0]}, 32'h01);
      chk("pp_ch1_1", {24'd0, got1[1]}, 32'h03);
      chk("pp_ch2_0", {24'd0, got2[0]}, 32'h02);
      chk("pp_ch2_1", {24'd0, got2[1]}, 32'h04);
    end
    chk("pp_cnt1", {24'd0, o_cnt1}, 32'd2);
    chk("pp_cnt2", {24'd0, o_cnt2}, 32'd2);

    // Strict-order stall: pointer on ch2, ch2 full and stalled, ch1 free
    tick(1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, rdy);
    tick(1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, rdy);
    tick(1'b1, 8'h30, 1'b0, 1'b1, 1'b1, 1'b0, rdy);
    chk("st_cnt1_pre", {24'd0, o_cnt1}, 32'd4);
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 8'h40, 1'b0, 1'b1, 1'b1, 1'b0, rdy);
      chk("st_rdy", {31'd0, rdy}, 32'd0);
      chk("st_ch1_empty", {31'd0, o_valid1}, 32'd0);
      chk("st_cnt1", {24'd0, o_cnt1}, 32'd4);
      chk("st_ch2_held", {24'd0, o_data2}, 32'h20);
    end
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
    tick(1'b1, 8'h40, 1'b0, 1'b1, 1'b1, 1'b0, rdy);
    chk("st_resume_rdy", {31'd0, rdy}, 32'd1);
    chk("st_resume_d1", {24'd0, o_data1}, 32'h40);
    chk("st_resume_cnt1", {24'd0, o_cnt1}, 32'd5);
    chk("st_resume_cnt2", {24'd0, o_cnt2}, 32'd3);

    // Counter wrap on channel 1
    do_reset();
    for (int k = 1; k <= 256; k++) begin
      tick(1'b1, 8'(k), 1'b0, 1'b0, 1'b1, 1'b0, rdy);
      if (k == 255) chk("wrap_255", {24'd0, o_cnt1}, 32'd255);
      if (k == 256) chk("wrap_0", {24'd0, o_cnt1}, 32'd0);
    end
    for (int k = 0; k < 7; k++) begin
      tick(1'b1, 8'(8'h60 + k), 1'b0, 1'b0, 1'b1, 1'b0, rdy);
    end
    chk("pre_arst_cnt1", {24'd0, o_cnt1}, 32'd7);
    chk("pre_arst_v1", {31'd0, o_valid1}, 32'd1);

    // Asynchronous reset between edges
    #1 i_rst = 1'b1;
    #1;
    chk("arst_v1", {31'd0, o_valid1}, 32'd0);
    chk("arst_d1", {24'd0, o_data1}, 32'd0);
    chk("arst_cnt1", {24'd0, o_cnt1}, 32'd0);
    chk("arst_ready", {31'd0, o_ready}, 32'd0);
    @(negedge clk);
    #1 i_valid = 1'b0;
    @(posedge clk);
    #2;
    @(negedge clk);
    #1 i_rst = 1'b0;
    @(posedge clk);
    #2;

    // First accept after reset release
    tick(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
    chk("post_rdy", {31'd0, rdy}, 32'd1);
    chk("post_d1", {24'd0, o_data1}, 32'h77);
    chk("post_cnt1", {24'd0, o_cnt1}, 32'd1);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, rdy);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
